// File: rtl/arm_instr_encoder.sv
// Packs ARM instruction field bundles into 32-bit words and streams them into
// instruction memory from address 0, keeping a running XOR checksum.
module arm_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic              Last,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rn,
  input  logic [3:0]        Rd,
  input  logic [11:0]       Src2,
  output logic              IMemWE,
  output logic [ADDR_W-1:0] IMemAddr,
  output logic [31:0]       IMemWD,
  output logic [ADDR_W:0]   Count,
  output logic [31:0]       Checksum,
  output logic              Done,
  output logic [1:0]        Error,
  output logic [1:0]        dbg_state
);

  // Handshake: a bundle is consumed on a rising edge where InValid and InReady
  // are both high; InReady is registered and only high while waiting in LOAD.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [31:0] enc_word;
  logic        last_q;
  logic        accept;
  logic        illegal;

  assign accept    = (state == S_LOAD) && InValid;
  assign illegal   = (Op == 2'b11);
  assign dbg_state = state;

  // Branch imm24 is built from the 20-bit {Rn,Rd,Src2}, sign-extended, so
  // short backward branches (e.g. -2 = FFFFE) encode correctly; Funct[3:0] unused.
  always_comb begin
    enc_word = {Cond, Op, Funct, Rn, Rd, Src2};
    if (Op == 2'b10) begin
      enc_word = {Cond, 2'b10, Funct[5:4], {4{Rn[3]}}, Rn, Rd, Src2};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (!illegal)  state_nxt = S_WRITE;
          else if (Last) state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (last_q || (IMemAddr == ADDR_MAX)) state_nxt = S_DONE;
        else                                   state_nxt = S_LOAD;
      end
      S_DONE: begin
        if (Start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so nothing is combinational.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      InReady <= 1'b0;
      IMemWE  <= 1'b0;
      Done    <= 1'b0;
    end else begin
      InReady <= (state_nxt == S_LOAD);
      IMemWE  <= (state_nxt == S_WRITE);
      Done    <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      IMemAddr <= '0;
      IMemWD   <= '0;
      Count    <= '0;
      Checksum <= '0;
      Error    <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            IMemAddr <= '0;
            Count    <= '0;
            Checksum <= '0;
            Error    <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (!illegal) begin
              IMemWD <= enc_word;
              last_q <= Last;
            end else begin
              Error[0] <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          Checksum <= Checksum ^ IMemWD;
          Count    <= Count + CNT_ONE;
          if (!last_q) begin
            if (IMemAddr == ADDR_MAX) Error[1] <= 1'b1;
            else                      IMemAddr <= IMemAddr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Bench for arm_instr_encoder: a 64-word and a 4-word instance share stimulus
// and are checked every cycle against a session-level model.
module tb_arm_instr_encoder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        Start = 1'b0;
  logic        InValid = 1'b0;
  logic        Last = 1'b0;
  logic [3:0]  Cond = '0;
  logic [1:0]  Op = '0;
  logic [5:0]  Funct = '0;
  logic [3:0]  Rn = '0;
  logic [3:0]  Rd = '0;
  logic [11:0] Src2 = '0;

  logic        b_InReady, b_IMemWE, b_Done;
  logic [5:0]  b_IMemAddr;
  logic [31:0] b_IMemWD, b_Checksum;
  logic [6:0]  b_Count;
  logic [1:0]  b_Error, b_dbg;

  logic        s_InReady, s_IMemWE, s_Done;
  logic [1:0]  s_IMemAddr;
  logic [31:0] s_IMemWD, s_Checksum;
  logic [2:0]  s_Count;
  logic [1:0]  s_Error, s_dbg;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 CLK = ~CLK;

  arm_instr_encoder #(.ADDR_W(6)) u_big (
    .CLK(CLK), .nRST(nRST), .Start(Start), .InValid(InValid), .InReady(b_InReady),
    .Last(Last), .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Src2(Src2),
    .IMemWE(b_IMemWE), .IMemAddr(b_IMemAddr), .IMemWD(b_IMemWD), .Count(b_Count),
    .Checksum(b_Checksum), .Done(b_Done), .Error(b_Error), .dbg_state(b_dbg)
  );

  arm_instr_encoder #(.ADDR_W(2)) u_small (
    .CLK(CLK), .nRST(nRST), .Start(Start), .InValid(InValid), .InReady(s_InReady),
    .Last(Last), .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Src2(Src2),
    .IMemWE(s_IMemWE), .IMemAddr(s_IMemAddr), .IMemWD(s_IMemWD), .Count(s_Count),
    .Checksum(s_Checksum), .Done(s_Done), .Error(s_Error), .dbg_state(s_dbg)
  );

  // ---------------- session model ----------------
  int  m_max[2] = '{63, 3};
  bit  m_open[2], m_pend[2], m_lastw[2], m_done[2];
  int  m_addr[2], m_cnt[2], m_err[2];
  logic [31:0] m_wd[2], m_cs[2];

  function automatic logic [31:0] encode(input int c, input int o, input int f,
                                         input int n, input int d, input int s2);
    longint w;
    longint imm;
    if (o == 2) begin
      imm = longint'(n) * 65536 + longint'(d) * 4096 + longint'(s2);
      if (imm >= 524288) imm = imm + 15 * 1048576;
      w = longint'(c) * 268435456 + 2 * 67108864 + longint'(f / 16) * 16777216 + imm;
    end else begin
      w = longint'(c) * 268435456 + longint'(o) * 67108864 + longint'(f) * 1048576
        + longint'(n) * 65536 + longint'(d) * 4096 + longint'(s2);
    end
    return w[31:0];
  endfunction

  always @(posedge CLK or negedge nRST) begin
    for (int i = 0; i < 2; i++) begin
      if (!nRST) begin
        m_open[i] = 0; m_pend[i] = 0; m_lastw[i] = 0; m_done[i] = 0;
        m_addr[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_wd[i] = 0; m_cs[i] = 0;
      end else if (m_pend[i]) begin
        m_cs[i]   = m_cs[i] ^ m_wd[i];
        m_cnt[i]  = m_cnt[i] + 1;
        m_pend[i] = 0;
        if (m_lastw[i]) begin
          m_open[i] = 0; m_done[i] = 1;
        end else if (m_addr[i] == m_max[i]) begin
          m_err[i] = m_err[i] | 2; m_open[i] = 0; m_done[i] = 1;
        end else begin
          m_addr[i] = m_addr[i] + 1;
        end
      end else if (m_open[i]) begin
        if (InValid) begin
          if (Op != 2'b11) begin
            m_wd[i] = encode(int'(Cond), int'(Op), int'(Funct), int'(Rn), int'(Rd), int'(Src2));
            m_lastw[i] = Last;
            m_pend[i] = 1;
          end else begin
            m_err[i] = m_err[i] | 1;
            if (Last) begin
              m_open[i] = 0; m_done[i] = 1;
            end
          end
        end
      end else if (Start) begin
        m_open[i] = 1; m_done[i] = 0;
        m_addr[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_cs[i] = 0;
      end
    end
  end

  function automatic bit e_ready(input int i);
    return m_open[i] && !m_pend[i];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input int i, input string p, input logic rdy, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] cnt,
                     input logic [31:0] cs, input logic dn, input logic [1:0] er);
    chk({p, "_inready"},  {31'd0, rdy}, {31'd0, e_ready(i)});
    chk({p, "_imemwe"},   {31'd0, we},  {31'd0, m_pend[i]});
    chk({p, "_imemaddr"}, addr, m_addr[i]);
    chk({p, "_imemwd"},   wd, m_wd[i]);
    chk({p, "_count"},    cnt, m_cnt[i]);
    chk({p, "_checksum"}, cs, m_cs[i]);
    chk({p, "_done"},     {31'd0, dn}, {31'd0, m_done[i]});
    chk({p, "_error"},    {30'd0, er}, m_err[i]);
  endtask

  logic [31:0] b_log_a[$], b_log_d[$], s_log_a[$], s_log_d[$];

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp(0, "big", b_InReady, b_IMemWE, 32'(b_IMemAddr), b_IMemWD, 32'(b_Count),
          b_Checksum, b_Done, b_Error);
      cmp(1, "small", s_InReady, s_IMemWE, 32'(s_IMemAddr), s_IMemWD, 32'(s_Count),
          s_Checksum, s_Done, s_Error);
      if (b_IMemWE) begin b_log_a.push_back(32'(b_IMemAddr)); b_log_d.push_back(b_IMemWD); end
      if (s_IMemWE) begin s_log_a.push_back(32'(s_IMemAddr)); s_log_d.push_back(s_IMemWD); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_session();
    @(posedge CLK); #1;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    b_log_a.delete(); b_log_d.delete(); s_log_a.delete(); s_log_d.delete();
  endtask

  task automatic send(input int sel, input logic [3:0] c, input logic [1:0] o,
                      input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
                      input logic [11:0] s2, input logic l, input bit expect_acc);
    bit acc = 0;
    Cond = c; Op = o; Funct = f; Rn = n; Rd = d; Src2 = s2; Last = l;
    InValid = 1'b1;
    for (int k = 0; k < 8 && !acc; k++) begin
      @(negedge CLK);
      if (e_ready(sel)) begin
        acc = 1;
        @(posedge CLK); #1;
      end
    end
    n_vec++;
    if (acc != expect_acc) begin
      n_err++;
      $display("FAIL accept @%0t: got %0d expected %0d", $time, acc, expect_acc);
    end
  endtask

  task automatic wait_done(input int sel);
    bit ok = 0;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge CLK);
      if (m_done[sel]) ok = 1;
    end
    InValid = 1'b0;
    Last = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL done_timeout @%0t: got 0 expected 1", $time);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    @(posedge CLK); #1;
    chk_en = 1;
    @(posedge CLK); #1;
    nRST = 1'b1;
    chk("rst_inready", {31'd0, b_InReady}, 32'd0);
    chk("rst_imemwe",  {31'd0, b_IMemWE}, 32'd0);
    chk("rst_count",   32'(b_Count), 32'd0);
    chk("rst_checksum", b_Checksum, 32'd0);
    chk("rst_done_err", {29'd0, b_Done, b_Error}, 32'd0);

    // ADD R1,R2,#5
    start_session();
    send(0, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 1'b1, 1);
    wait_done(0);
    chk("add_nwrites", b_log_a.size(), 32'd1);
    if (b_log_a.size() >= 1) begin
      chk("add_addr", b_log_a[0], 32'd0);
      chk("add_word", b_log_d[0], 32'hE2821005);
    end
    chk("add_count", 32'(b_Count), 32'd1);
    chk("add_checksum", b_Checksum, 32'hE2821005);
    chk("add_done_err", {29'd0, b_Done, b_Error}, 32'd4);

    // LDR R3,[R4,#8] then B -2 (Funct[3:0] = 0 so the sign extension is exercised)
    start_session();
    send(0, 4'hE, 2'b01, 6'b011001, 4'd4, 4'd3, 12'h008, 1'b0, 1);
    send(0, 4'hE, 2'b10, 6'b100000, 4'hF, 4'hF, 12'hFFE, 1'b1, 1);
    wait_done(0);
    chk("ldrb_nwrites", b_log_a.size(), 32'd2);
    if (b_log_a.size() >= 2) begin
      chk("ldr_word", b_log_d[0], 32'hE5943008);
      chk("b_addr", b_log_a[1], 32'd1);
      chk("b_word", b_log_d[1], 32'hEAFFFFFE);
    end
    chk("ldrb_checksum", b_Checksum, 32'h0F6BCFF6);

    // Positive branch with Funct[3:0] set: those bits must not leak in
    start_session();
    send(0, 4'h0, 2'b10, 6'b011111, 4'h1, 4'h2, 12'h345, 1'b1, 1);
    wait_done(0);
    chk("bpos_word", b_IMemWD, 32'h09012345);

    // Illegal Op mid-stream; a stray Start while loading is ignored
    start_session();
    start_session();
    send(0, 4'hE, 2'b00, 6'b000100, 4'd1, 4'd2, 12'h003, 1'b0, 1);
    send(0, 4'hE, 2'b11, 6'b111111, 4'd7, 4'd7, 12'h777, 1'b0, 1);
    send(0, 4'h1, 2'b00, 6'b011010, 4'd0, 4'd5, 12'h0FF, 1'b1, 1);
    wait_done(0);
    chk("ill_nwrites", b_log_a.size(), 32'd2);
    if (b_log_a.size() >= 2) chk("ill_addr1", b_log_a[1], 32'd1);
    chk("ill_error", {30'd0, b_Error}, 32'd1);
    chk("ill_count", 32'(b_Count), 32'd2);

    // Overflow on the 4-word instance: fifth bundle never accepted
    start_session();
    for (int j = 0; j < 4; j++)
      send(1, 4'hE, 2'b00, 6'b001000, 4'd0, 4'(j), 12'(j), 1'b0, 1);
    send(1, 4'hE, 2'b00, 6'b001000, 4'd0, 4'd4, 12'h004, 1'b1, 0);
    wait_done(1);
    chk("ovf_nwrites", s_log_a.size(), 32'd4);
    if (s_log_a.size() >= 4) chk("ovf_addr3", s_log_a[3], 32'd3);
    chk("ovf_error", {30'd0, s_Error}, 32'd2);
    chk("ovf_count", 32'(s_Count), 32'd4);
    chk("ovf_done", {31'd0, s_Done}, 32'd1);

    // Back-to-back with InValid held high
    start_session();
    send(0, 4'hA, 2'b00, 6'b000001, 4'd3, 4'd4, 12'h111, 1'b0, 1);
    send(0, 4'hB, 2'b01, 6'b100000, 4'd5, 4'd6, 12'h222, 1'b0, 1);
    send(0, 4'hC, 2'b00, 6'b110011, 4'd7, 4'd8, 12'h333, 1'b1, 1);
    wait_done(0);
    chk("b2b_nwrites", b_log_a.size(), 32'd3);

    // Reset during WRITE
    start_session();
    send(0, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 1'b1, 1);
    #2;
    nRST = 1'b0;
    InValid = 1'b0;
    #1;
    chk("rstw_imemwe", {31'd0, b_IMemWE}, 32'd0);
    chk("rstw_imemwd", b_IMemWD, 32'd0);
    chk("rstw_inready_done", {30'd0, b_InReady, b_Done}, 32'd0);
    #4;
    nRST = 1'b1;
    start_session();
    send(0, 4'h3, 2'b01, 6'b011001, 4'd9, 4'd10, 12'h010, 1'b1, 1);
    wait_done(0);
    chk("rstw_nwrites", b_log_a.size(), 32'd1);
    if (b_log_a.size() >= 1) chk("rstw_addr", b_log_a[0], 32'd0);
    chk("rstw_count", 32'(b_Count), 32'd1);

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
